window_scan_ctrl: RTL
=====================

WINDOW_SCAN_CTRL -- requirements
Module: window_scan_ctrl

Interface
REQ-001 Parameter IMG_W, default 16, image width in pixels; legal range 3..4096.
REQ-002 Parameter IMG_H, default 16, image height in pixels; legal range 3..4096.
REQ-003 Parameter ADDR_W, default 16, pixel address width; ADDR_W SHALL satisfy 2^ADDR_W >= IMG_W*IMG_H.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 n_rst  in  1  reset, synchronous, active-low.
REQ-006 frame_start  in  1  one-cycle request to scan one frame.
REQ-007 start_read  out  1  one-cycle pulse to the window buffer: load data_r into slot `count`.
REQ-008 read_done  in  1  the window buffer has completed the current read.
REQ-009 start_shift  out  1  one-cycle pulse to the window buffer: shift the window.
REQ-010 shift_direc  out  2  shift direction: 01 right, 10 down, 11 left; 00 when not shifting.
REQ-011 shift_done  in  1  the window buffer has completed the current shift.
REQ-012 count  out  4  target window slot 0..8, row-major; slot 0 is top-left.
REQ-013 rd_addr  out  ADDR_W  pixel memory address = row*IMG_W + col.
REQ-014 win_valid  out  1  all 9 slots hold the current window.
REQ-015 win_ack  in  1  downstream Sobel stage has consumed the window.
REQ-016 win_x, win_y  out  12 each  window centre column/row.
REQ-017 busy  out  1  a frame is in progress; frame_done  out  1  one-cycle pulse after the last window is acked.

Function
REQ-018 States SHALL be IDLE, FILL_REQ, FILL_WAIT, WIN_RDY, SHIFT_REQ, SHIFT_WAIT, LOAD_REQ, LOAD_WAIT and DONE.
REQ-019 IDLE: on frame_start, set centre (1,1), clear the slot counter, and go to FILL_REQ; busy=1 from the next cycle.
REQ-020 FILL_REQ: pulse start_read for exactly 1 cycle, with rd_addr/count held stable from this cycle until read_done, then go to FILL_WAIT.
REQ-021 Fill order: slots 0..8 cover rows y-1..y+1 and columns x-1..x+1, row-major.
REQ-022 FILL_WAIT: on read_done, advance the slot; after slot 8 go to WIN_RDY, otherwise return to FILL_REQ.
REQ-023 WIN_RDY: hold win_valid=1 until win_ack; win_x/win_y stable while win_valid=1.
REQ-024 On win_ack, choose the next move by serpentine order, then go to SHIFT_REQ, or to DONE if it was the last window:
- even row (y-1 even) and x<IMG_W-2: move right;
- odd row and x>1: move left;
- otherwise, if y<IMG_H-2: move down;
- otherwise: last window.
REQ-025 SHIFT_REQ: pulse start_shift for exactly 1 cycle with shift_direc valid; hold shift_direc until shift_done; go to SHIFT_WAIT.
REQ-026 SHIFT_WAIT: on shift_done, update the centre (x+1, x-1 or y+1) and go to LOAD_REQ for 3 reads.
REQ-027 New-data slots and addresses for the 3 reads, in this order:
- right: slots 2,5,8 at column x+1, rows y-1..y+1;
- left: slots 0,3,6 at column x-1, rows y-1..y+1;
- down: slots 6,7,8 at row y+1, columns x-1..x+1.
REQ-028 LOAD_REQ/LOAD_WAIT follow the FILL handshake (REQ-020/022); after the third read_done, go to WIN_RDY.
REQ-029 DONE: pulse frame_done for 1 cycle, drop busy, and return to IDLE.
REQ-030 frame_start while busy=1 SHALL be ignored.
REQ-031 start_read and start_shift SHALL never be asserted in the same cycle; neither is asserted again before the matching done.
REQ-032 read_done/shift_done arriving outside the matching WAIT state SHALL be ignored.
REQ-033 If read_done arrives in the same cycle as the start_read pulse, it SHALL be ignored; the WAIT state waits for a later read_done (likewise for shift_done).
REQ-034 Address arithmetic SHALL be unsigned, at ADDR_W width, with no wrap for legal parameters.

Reset
REQ-035 n_rst=0 at a rising edge SHALL, at any state including mid-frame:
- force IDLE;
- clear start_read, start_shift, win_valid, busy, frame_done;
- set shift_direc=00, count=0, rd_addr=0, win_x=win_y=0.
REQ-036 After n_rst returns high, the block SHALL stay IDLE until a new frame_start.

Verification (IMG_W=4, IMG_H=4; read_done/shift_done returned 2 cycles after each pulse; win_ack 1 cycle after win_valid)
REQ-037 Fill: frame_start -> 9 start_read pulses with rd_addr 0,1,2,4,5,6,8,9,10 and count 0..8 -> win_valid with (win_x,win_y)=(1,1).
REQ-038 Right then down:
- ack -> start_shift with direc=01 -> reads 3,7,11 into slots 2,5,8 -> window (2,1);
- ack -> start_shift with direc=10 -> reads 13,14,15 into slots 6,7,8 -> window (2,2).
REQ-039 Left and finish: ack -> direc=11 -> reads 4,8,12 into slots 0,3,6 -> window (1,2); ack -> frame_done pulse, busy=0; 4 windows in total.
REQ-040 Stall: win_ack withheld 20 cycles -> win_valid, win_x and win_y held; no start_read/start_shift issued.
REQ-041 Reset mid-frame: n_rst=0 during LOAD_WAIT -> all outputs at reset values next edge; frame_start re-fills from address 0.
REQ-042 Spurious inputs: frame_start pulsed while busy, and an extra read_done in WIN_RDY -> address and window sequence unchanged.

Source files
------------

// File: rtl/window_scan_ctrl.sv
// -----------------------------------------------------------------------------
// window_scan_ctrl
//
// Drives a 3x3 window buffer across an IMG_W x IMG_H image in serpentine order
// (right along even rows, left along odd rows, one step down at each row end).
// The first window of a frame is filled with nine reads. Every later window is
// produced by one shift of the buffer followed by three reads that supply the
// newly exposed column or row.
//
// Ports
//   clk          single clock, rising edge
//   n_rst        synchronous active-low reset
//   frame_start  one-cycle request to scan a frame (ignored while busy)
//   start_read   one-cycle pulse: load pixel rd_addr into window slot count
//   read_done    window buffer finished the current read
//   start_shift  one-cycle pulse: shift the window in direction shift_direc
//   shift_direc  01 right, 10 down, 11 left, 00 when no shift is pending
//   shift_done   window buffer finished the current shift
//   count        target window slot 0..8, row-major, slot 0 top-left
//   rd_addr      pixel address row*IMG_W + col
//   win_valid    all nine slots hold the window centred at (win_x, win_y)
//   win_ack      downstream stage consumed the window
//   win_x/win_y  window centre column/row
//   busy         a frame is in progress
//   frame_done   one-cycle pulse after the last window was acknowledged
// -----------------------------------------------------------------------------
module window_scan_ctrl #(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              frame_start,
  output logic              start_read,
  input  logic              read_done,
  output logic              start_shift,
  output logic [1:0]        shift_direc,
  input  logic              shift_done,
  output logic [3:0]        count,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              win_valid,
  input  logic              win_ack,
  output logic [11:0]       win_x,
  output logic [11:0]       win_y,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [3:0] {
    IDLE,
    FILL_REQ,
    FILL_WAIT,
    WIN_RDY,
    SHIFT_REQ,
    SHIFT_WAIT,
    LOAD_REQ,
    LOAD_WAIT,
    DONE
  } state_t;

  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  // Last legal centre column/row; the window never touches the image border
  // with its centre.
  localparam logic [11:0] X_LAST = 12'(IMG_W - 2);
  localparam logic [11:0] Y_LAST = 12'(IMG_H - 2);

  // Unsigned address at full ADDR_W width; legal parameters never overflow.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [11:0] row,
                                                 input logic [11:0] col);
    pix_addr = ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
  endfunction

  state_t      state, state_n;
  logic [11:0] cx, cx_n;
  logic [11:0] cy, cy_n;
  logic [11:0] row, row_n;      // pixel row of the pending read
  logic [11:0] col, col_n;      // pixel column of the pending read
  logic [3:0]  slot, slot_n;    // window slot of the pending read
  logic [1:0]  ld_cnt, ld_cnt_n;
  logic [1:0]  dir, dir_n;      // direction of the last move, kept for loads
  logic [1:0]  direc_n;

  // ---------------------------------------------------------------------------
  // Next-state and next-datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n  = state;
    cx_n     = cx;
    cy_n     = cy;
    row_n    = row;
    col_n    = col;
    slot_n   = slot;
    ld_cnt_n = ld_cnt;
    dir_n    = dir;
    direc_n  = shift_direc;

    unique case (state)
      IDLE: begin
        if (frame_start) begin
          cx_n    = 12'd1;
          cy_n    = 12'd1;
          row_n   = 12'd0;
          col_n   = 12'd0;
          slot_n  = 4'd0;
          state_n = FILL_REQ;
        end
      end

      FILL_REQ: state_n = FILL_WAIT;

      // Completions are only looked at here, so a done that coincides with
      // the request pulse, or that arrives in any other state, is dropped.
      FILL_WAIT: begin
        if (read_done) begin
          if (slot == 4'd8) begin
            state_n = WIN_RDY;
          end else begin
            slot_n = slot + 4'd1;
            if (col == cx + 12'd1) begin
              col_n = cx - 12'd1;
              row_n = row + 12'd1;
            end else begin
              col_n = col + 12'd1;
            end
            state_n = FILL_REQ;
          end
        end
      end

      // Window row y-1 is even exactly when the centre row y is odd.
      WIN_RDY: begin
        if (win_ack) begin
          if (cy[0] && (cx < X_LAST)) begin
            dir_n   = DIR_RIGHT;
            direc_n = DIR_RIGHT;
            state_n = SHIFT_REQ;
          end else if (!cy[0] && (cx > 12'd1)) begin
            dir_n   = DIR_LEFT;
            direc_n = DIR_LEFT;
            state_n = SHIFT_REQ;
          end else if (cy < Y_LAST) begin
            dir_n   = DIR_DOWN;
            direc_n = DIR_DOWN;
            state_n = SHIFT_REQ;
          end else begin
            state_n = DONE;
          end
        end
      end

      SHIFT_REQ: state_n = SHIFT_WAIT;

      // Move the centre and aim the first of three reads at the strip of
      // pixels the shift exposed.
      SHIFT_WAIT: begin
        if (shift_done) begin
          direc_n  = DIR_NONE;
          ld_cnt_n = 2'd0;
          state_n  = LOAD_REQ;
          unique case (dir)
            DIR_RIGHT: begin
              cx_n   = cx + 12'd1;
              row_n  = cy - 12'd1;
              col_n  = cx + 12'd2;
              slot_n = 4'd2;
            end
            DIR_LEFT: begin
              cx_n   = cx - 12'd1;
              row_n  = cy - 12'd1;
              col_n  = cx - 12'd2;
              slot_n = 4'd0;
            end
            default: begin
              cy_n   = cy + 12'd1;
              row_n  = cy + 12'd2;
              col_n  = cx - 12'd1;
              slot_n = 4'd6;
            end
          endcase
        end
      end

      LOAD_REQ: state_n = LOAD_WAIT;

      // Horizontal moves load a column (slot stride 3), a down move loads a
      // row (slot stride 1).
      LOAD_WAIT: begin
        if (read_done) begin
          if (ld_cnt == 2'd2) begin
            state_n = WIN_RDY;
          end else begin
            ld_cnt_n = ld_cnt + 2'd1;
            if (dir == DIR_DOWN) begin
              col_n  = col + 12'd1;
              slot_n = slot + 4'd1;
            end else begin
              row_n  = row + 12'd1;
              slot_n = slot + 4'd3;
            end
            state_n = LOAD_REQ;
          end
        end
      end

      DONE: state_n = IDLE;

      default: state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state       <= IDLE;
      cx          <= 12'd0;
      cy          <= 12'd0;
      row         <= 12'd0;
      col         <= 12'd0;
      slot        <= 4'd0;
      ld_cnt      <= 2'd0;
      dir         <= DIR_NONE;
      shift_direc <= DIR_NONE;
      rd_addr     <= '0;
    end else begin
      state       <= state_n;
      cx          <= cx_n;
      cy          <= cy_n;
      row         <= row_n;
      col         <= col_n;
      slot        <= slot_n;
      ld_cnt      <= ld_cnt_n;
      dir         <= dir_n;
      shift_direc <= direc_n;
      // Registered so address and slot are stable from the request pulse
      // until the matching completion.
      rd_addr     <= pix_addr(row_n, col_n);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from state
  // ---------------------------------------------------------------------------
  assign start_read  = (state == FILL_REQ) || (state == LOAD_REQ);
  assign start_shift = (state == SHIFT_REQ);
  assign win_valid   = (state == WIN_RDY);
  assign busy        = (state != IDLE) && (state != DONE);
  assign frame_done  = (state == DONE);
  assign count       = slot;
  assign win_x       = cx;
  assign win_y       = cy;

endmodule
